// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state type, oversampling constants and majority-vote helper
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_e;
   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_W = $clog2(OVERSAMPLE);
   localparam logic [SAMPLE_W-1:0] SAMPLE_A = SAMPLE_W'(7);
   localparam logic [SAMPLE_W-1:0] SAMPLE_B = SAMPLE_W'(8);
   localparam logic [SAMPLE_W-1:0] SAMPLE_C = SAMPLE_W'(9);
   localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(OVERSAMPLE - 1);
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for an asynchronous input, resets to 1 (idle-high pads)
module bit_synchronizer #(
   parameter int STAGES = 2
)(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] r_sync;
   always_ff @(posedge i_clk)
      r_sync <= i_reset ? '1 : {r_sync[STAGES-2:0], i_d};
   assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, 16x oversampling with 3-sample majority vote, valid/ready byte output
module uart_rx import uart_pkg::*; #(
   parameter int DATA_BITS   = 8,
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
)(
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 rx_i,
   input  logic [DIV_W-1:0]     baud_div_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 frame_err_o,
   output logic                 overrun_o,
   output logic                 busy_o
);
   localparam int CNT_W = $clog2(DATA_BITS + 1);
   uart_rx_state_e r_state, w_next;
   logic w_rxs, r_rxs_d, w_start, w_tick, w_at9, w_at15, w_bit9, w_bit15;
   logic w_last_bit, w_done, w_ferr;
   logic r_a, r_b, r_c, r_valid, r_ferr, r_ovr;
   logic [DIV_W-1:0] r_div_q, r_cnt;
   logic [SAMPLE_W-1:0] r_s;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift, r_data;
   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk(clk_i), .i_reset(reset_i), .i_d(rx_i), .o_q(w_rxs)
   );
   assign w_start = r_rxs_d & ~w_rxs;
   assign w_tick = (r_state != IDLE) && (r_cnt == '0);
   assign w_at9 = w_tick && (r_s == SAMPLE_C);
   assign w_at15 = w_tick && (r_s == LAST_SAMPLE);
   // the third vote is taken live at the s=9 tick so decisions need not wait a cycle
   assign w_bit9 = maj3(r_a, r_b, w_rxs);
   assign w_bit15 = maj3(r_a, r_b, r_c);
   assign w_last_bit = r_bit_cnt == CNT_W'(DATA_BITS - 1);
   always_ff @(posedge clk_i)
      r_state <= reset_i ? IDLE : w_next;
   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      w_ferr = 1'b0;
      case (r_state)
         IDLE:  w_next = w_start ? START : IDLE;
         START: w_next = (w_at9 && w_bit9) ? IDLE : w_at15 ? DATA : START;
         DATA:  w_next = (w_at15 && w_last_bit) ? STOP : DATA;
         STOP: begin
            w_next = w_at9 ? IDLE : STOP;
            w_done = w_at9 & w_bit9;
            w_ferr = w_at9 & ~w_bit9;
         end
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_rxs_d <= 1'b1;
         r_div_q <= '0;
         r_cnt <= '0;
         r_s <= '0;
         r_a <= 1'b0;
         r_b <= 1'b0;
         r_c <= 1'b0;
         r_bit_cnt <= '0;
         r_shift <= '0;
         r_data <= '0;
         r_valid <= 1'b0;
         r_ferr <= 1'b0;
         r_ovr <= 1'b0;
      end else begin
         r_rxs_d <= w_rxs;
         if (r_state == IDLE) begin
            if (w_start) begin
               r_div_q <= baud_div_i;
               r_cnt <= baud_div_i;
               r_s <= '0;
            end
         end else begin
            r_cnt <= w_tick ? r_div_q : r_cnt - 1'b1;
         end
         if (w_tick) begin
            r_s <= r_s + 1'b1;
            if (r_s == SAMPLE_A) r_a <= w_rxs;
            if (r_s == SAMPLE_B) r_b <= w_rxs;
            if (r_s == SAMPLE_C) r_c <= w_rxs;
         end
         if (r_state == START && w_at15) r_bit_cnt <= '0;
         if (r_state == DATA && w_at15) begin
            r_shift <= {w_bit15, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         r_ferr <= w_ferr;
         r_ovr <= w_done & r_valid & ~ready_i;
         if (w_done && (!r_valid || ready_i)) begin
            r_data <= r_shift;
            r_valid <= 1'b1;
         end else if (ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end
   assign data_o = r_data;
   assign valid_o = r_valid;
   assign frame_err_o = r_ferr;
   assign overrun_o = r_ovr;
   assign busy_o = r_state != IDLE;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the UART0 rx pin that the top-level wrapper routes into the SoC peripheral interface.
- Synchronises the asynchronous rx line and recovers 8N1 frames using 16x oversampling with a 3-sample majority vote.
- Presents each received byte on a valid/ready handshake to the UART0 register block.
- Runs entirely in the CPU clock domain (clk_wiz output).

Parameters:
- DATA_BITS, 8, data bits per frame; LSB first; no parity.
- DIV_W, 16, width of the baud divisor input.
- SYNC_STAGES, 2, flip-flop stages on rx_i; minimum 2.

Ports:
- clk_i  in  1  CPU clock; sole clock.
- reset_i  in  1  synchronous, active-high reset.
- rx_i  in  1  asynchronous serial input; idles high.
- baud_div_i  in  DIV_W  oversample tick period minus 1; one tick every baud_div_i+1 cycles.
- data_o  out  DATA_BITS  received byte.
- valid_o  out  1  data_o holds an unconsumed byte.
- ready_i  in  1  consumer accepts data_o this cycle.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: a byte was dropped.
- busy_o  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset values:
  - Synchroniser stages: 1.
  - State: IDLE.
  - data_o, valid_o, frame_err_o, overrun_o, busy_o: 0.
  - All counters: 0.
- Reset asserted mid-frame aborts the frame and drops any held byte.
- rxs is rx_i after SYNC_STAGES flops. Start is detected on rxs transitioning 1 -> 0, using a 1-cycle delayed copy of rxs.
- Tick generator:
  - On leaving IDLE, baud_div_i is latched into div_q and the down-counter is loaded with div_q.
  - Tick fires when the counter is 0, then the counter reloads div_q.
  - The counter is held in IDLE.
  - Changing baud_div_i mid-frame has no effect until the next frame.
  - div_q = 0 gives a tick every cycle.
- Sample index s (0..15) increments on each tick and wraps 15 -> 0. rxs is captured on the ticks with s = 7, 8, 9. bit = majority of the three captures.
- State machine:
  - IDLE: on start edge -> START; s = 0.
  - START:
    - At the s=9 tick, if bit = 1 (false start) -> IDLE; no outputs.
    - Otherwise, at the s=15 tick -> DATA; bit_cnt = 0.
  - DATA:
    - At each s=15 tick, shift bit into the shift register MSB-side (LSB-first line order) and increment bit_cnt.
    - When bit_cnt reaches DATA_BITS -> STOP.
  - STOP: at the s=9 tick, decide and go -> IDLE the same cycle (re-arms half a bit early):
    - bit = 1: byte complete.
    - bit = 0: frame_err_o = 1 for the next cycle; byte discarded.
- Output handshake:
  - Transfer occurs when valid_o && ready_i; valid_o then drops the next cycle unless a new byte completes in the same cycle.
  - Byte completes while valid_o=0: data_o is loaded and valid_o = 1 on the next cycle.
  - Byte completes while valid_o=1 && ready_i=1: new byte loaded, valid_o stays 1, no overrun.
  - Byte completes while valid_o=1 && ready_i=0: new byte dropped, data_o unchanged, overrun_o pulses 1 cycle.
  - data_o is stable while valid_o=1 && ready_i=0.
- rxs held low (break condition): the frame ends with frame_err_o. No new start is detected until rxs returns high and falls again.
- Latency from start edge on rxs to valid_o: 154 ticks (16 + 16*DATA_BITS + 10) plus 1 cycle.

Decomposition:
- uart_pkg:
  - Typedef uart_rx_state_e {IDLE, START, DATA, STOP}.
  - Constants OVERSAMPLE=16, SAMPLE_A=7, SAMPLE_B=8, SAMPLE_C=9, LAST_SAMPLE=15.
  - uart_pkg is shared with the future uart_tx.
- Sub-module: bit_synchronizer (parameter STAGES, reset value 1). It is reused for other asynchronous pad inputs.

Test Plan:
- baud_div_i=3 (64 cycles/bit), send 0x55 at 8N1:
  - valid_o rises once, between 614 and 620 cycles after the rx_i fall.
  - data_o=0xA5? No: data_o=0x55.
  - frame_err_o and overrun_o stay 0.
- Back-to-back 0x00, 0xFF, 0x3C with ready_i tied 1 -> three one-cycle valid_o pulses carrying those values, in order.
- rx_i low for 20 cycles then high, baud_div_i=3 -> returns to IDLE at the s=9 tick of START; no valid_o, no frame_err_o; busy_o falls.
- Send 0xA3 with the stop bit driven low -> frame_err_o pulses once; valid_o stays 0; the next correct frame 0x12 is received normally.
- ready_i=0; send 0x11 then 0x22 -> valid_o=1 with data_o=0x11 held; overrun_o pulses once when 0x22 completes. Then ready_i=1 for 1 cycle -> valid_o=0.
- Assert reset_i for 1 cycle during DATA bit 4 of a frame -> all outputs 0 next cycle; the remaining frame bits do not produce valid_o; a following 0x7E is received correctly.
